// File: rtl/imm_extend_stage.sv
// Registered immediate extender between decode and ID/EX: field select, sign/zero
// extension and branch word-offset shift, behind a valid/ready skid buffer.
module imm_extend_stage #(
   parameter int IN_W     = 24,
   parameter int OUT_W    = 32,
   parameter int MEM_W    = 12,
   parameter int ALU_W    = 8,
   parameter int BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [1:0]       out_mode
);

   localparam logic [1:0] MODE_BR  = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_ALU = 2'b10;

   generate
      if (!(ALU_W <= MEM_W && MEM_W <= IN_W && IN_W <= OUT_W && BR_SHIFT < OUT_W
            && ALU_W > 0 && BR_SHIFT >= 0)) begin : g_bad_params
         $error("imm_extend_stage: illegal parameter set");
      end
   endgenerate

   logic             field_msb;
   logic             fill_bit;
   logic [OUT_W-1:0] ext_val;
   logic [OUT_W-1:0] result_next;

   always_comb begin
      case (in_mode)
         MODE_MEM: field_msb = in_imm[MEM_W-1];
         MODE_ALU: field_msb = in_imm[ALU_W-1];
         default:  field_msb = in_imm[IN_W-1];
      endcase
   end

   assign fill_bit = in_signed & field_msb;

   // Each output bit is either a field bit or the fill bit, depending on which
   // field widths it falls inside.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_ext
         if (gi < ALU_W) begin : g_alu
            assign ext_val[gi] = in_imm[gi];
         end else if (gi < MEM_W) begin : g_mem
            assign ext_val[gi] = (in_mode == MODE_ALU) ? fill_bit : in_imm[gi];
         end else if (gi < IN_W) begin : g_full
            assign ext_val[gi] = (in_mode == MODE_ALU || in_mode == MODE_MEM) ? fill_bit : in_imm[gi];
         end else begin : g_fill
            assign ext_val[gi] = fill_bit;
         end
      end
   endgenerate

   assign result_next = (in_mode == MODE_BR) ? (ext_val << BR_SHIFT) : ext_val;

   logic             or_valid_reg;
   logic [OUT_W-1:0] or_imm_reg;
   logic [1:0]       or_mode_reg;
   logic             sk_valid_reg;
   logic [OUT_W-1:0] sk_imm_reg;
   logic [1:0]       sk_mode_reg;
   logic             in_ready_reg;
   logic             in_fire;
   logic             out_fire;
   logic             sk_valid_next;

   assign in_fire  = in_valid & in_ready_reg;
   assign out_fire = or_valid_reg & out_ready;

   // Accepts never coincide with a full skid slot, so the skid only fills when
   // the output register is held and only empties on a drain.
   assign sk_valid_next = out_fire ? 1'b0 : (sk_valid_reg | (in_fire & or_valid_reg));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         or_valid_reg <= 1'b0;
         or_imm_reg   <= '0;
         or_mode_reg  <= '0;
         sk_valid_reg <= 1'b0;
         sk_imm_reg   <= '0;
         sk_mode_reg  <= '0;
         in_ready_reg <= 1'b0;
      end else begin
         if (out_fire) begin
            if (sk_valid_reg) begin
               or_imm_reg   <= sk_imm_reg;
               or_mode_reg  <= sk_mode_reg;
               sk_valid_reg <= 1'b0;
            end else if (in_fire) begin
               or_imm_reg  <= result_next;
               or_mode_reg <= in_mode;
            end else begin
               or_valid_reg <= 1'b0;
            end
         end else if (in_fire) begin
            if (!or_valid_reg) begin
               or_valid_reg <= 1'b1;
               or_imm_reg   <= result_next;
               or_mode_reg  <= in_mode;
            end else begin
               sk_valid_reg <= 1'b1;
               sk_imm_reg   <= result_next;
               sk_mode_reg  <= in_mode;
            end
         end
         in_ready_reg <= ~sk_valid_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = or_valid_reg;
   assign out_imm   = or_imm_reg;
   assign out_mode  = or_mode_reg;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed per-feature tasks plus an
// in-order scoreboard fed at input transfers and drained at output transfers.
module tb_imm_extend_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_imm = '0;
   logic [1:0]  in_mode = '0;
   logic        in_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_imm;
   logic [1:0]  out_mode;

   int vectors = 0;
   int miscompares = 0;
   logic [33:0] sb_q[$];

   imm_extend_stage dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_mode(in_mode), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_mode(out_mode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_ext(logic [23:0] imm, logic [1:0] mode, logic sgn);
      int w;
      logic [63:0] mask, field, v;
      case (mode)
         2'b01:   w = 12;
         2'b10:   w = 8;
         default: w = 24;
      endcase
      mask  = (64'd1 << w) - 64'd1;
      field = {40'd0, imm} & mask;
      v = field;
      if (sgn && field[w-1]) v = field | ~mask;
      if (mode == 2'b00) v = v << 2;
      return v[31:0];
   endfunction

   // Scoreboard: pop/compare on output transfer, push on input transfer.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         logic [33:0] exp_e;
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got imm=%h mode=%0d, required no output", out_imm, out_mode);
         end else begin
            exp_e = sb_q.pop_front();
            if ({out_mode, out_imm} !== exp_e) begin
               miscompares++;
               $display("FAIL sb_data: got mode=%0d imm=%h, required mode=%0d imm=%h",
                        out_mode, out_imm, exp_e[33:32], exp_e[31:0]);
            end
         end
      end
      if (reset_n && in_valid && in_ready)
         sb_q.push_back({in_mode, model_ext(in_imm, in_mode, in_signed)});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic [23:0] imm, input logic [1:0] mode, input logic sgn);
      bit done = 0;
      in_valid = 1'b1; in_imm = imm; in_mode = mode; in_signed = sgn;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = (in_ready === 1'b1);
         tick();
      end
      in_valid = 1'b0;
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required accept");
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_mode, out_imm} !== 36'd0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b rdy=%b mode=%0d imm=%h, required all 0",
                  out_valid, in_ready, out_mode, out_imm);
      end
      tick();
      reset_n = 1'b1;
      tick();
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, required 1", in_ready);
      end
      tick();
   endtask

   task automatic test_format(input string name, input logic [23:0] imm, input logic [1:0] mode,
                              input logic sgn, input logic [31:0] exp_imm);
      out_ready = 1'b1;
      send_one(imm, mode, sgn);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_imm !== exp_imm || out_mode !== mode) begin
         miscompares++;
         $display("FAIL %s: got v=%b imm=%h mode=%0d, required v=1 imm=%h mode=%0d",
                  name, out_valid, out_imm, out_mode, exp_imm, mode);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm = 24'h000003; in_mode = 2'b00; in_signed = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_a: got %b, required 1", in_ready); end
      tick();
      in_imm = 24'h7FF800; in_mode = 2'b01; in_signed = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_b: got %b, required 1", in_ready); end
      tick();
      in_imm = 24'hFFFF80; in_mode = 2'b10; in_signed = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h0000000C) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got rdy=%b v=%b imm=%h, required rdy=0 v=1 imm=0000000c",
                     i, in_ready, out_valid, out_imm);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (out_imm !== 32'h0000000C) begin miscompares++; $display("FAIL bp_out_a: got %h, required 0000000c", out_imm); end
      tick();
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_imm !== 32'h00000800) begin
         miscompares++;
         $display("FAIL bp_out_b: got rdy=%b v=%b imm=%h, required rdy=1 v=1 imm=00000800",
                  in_ready, out_valid, out_imm);
      end
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFF80) begin
         miscompares++;
         $display("FAIL bp_out_c: got v=%b imm=%h, required v=1 imm=ffffff80", out_valid, out_imm);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %b, required 0", out_valid); end
      tick();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_imm = 24'($urandom);
         in_mode = 2'($urandom_range(0, 3));
         in_signed = 1'($urandom_range(0, 1));
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
            miscompares++;
            $display("FAIL stream_%0d: got rdy=%b v=%b, required rdy=1 v=%0d", i, in_ready, out_valid, i > 0);
         end
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_last: got %b, required 1", out_valid); end
      tick();
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b, required 0", out_valid); end
      tick();
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      send_one(24'h000011, 2'b11, 1'b0);
      send_one(24'h000022, 2'b11, 1'b0);
      reset_n = 1'b0;
      tick();
      sb_q.delete();
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_mode, out_imm} !== 36'd0) begin
         miscompares++;
         $display("FAIL midop_reset: got v=%b rdy=%b mode=%0d imm=%h, required all 0",
                  out_valid, in_ready, out_mode, out_imm);
      end
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_after%0d: got v=%b rdy=%b, required v=0 rdy=1", i, out_valid, in_ready);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_format("br_neg",   24'h800001, 2'b00, 1'b1, 32'hFE000004);
      test_format("br_pos",   24'h000003, 2'b00, 1'b1, 32'h0000000C);
      test_format("raw_neg",  24'h800001, 2'b11, 1'b1, 32'hFF800001);
      test_format("br_uns",   24'hC00001, 2'b00, 1'b0, 32'h03000004);
      test_format("mem_s",    24'h7FF800, 2'b01, 1'b1, 32'hFFFFF800);
      test_format("mem_u",    24'h7FF800, 2'b01, 1'b0, 32'h00000800);
      test_format("mem_pos",  24'hFFF7FF, 2'b01, 1'b1, 32'h000007FF);
      test_format("alu_s",    24'hFFFF80, 2'b10, 1'b1, 32'hFFFFFF80);
      test_format("alu_u",    24'hFFFF80, 2'b10, 1'b0, 32'h00000080);
      test_backpressure();
      test_streaming();
      test_reset_midop();
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
